// File: rtl/if_pkg.sv
// if_pkg: shared widths, reset constants, FSM states and the IF/ID record for the fetch unit.
package if_pkg;
    localparam int PC_W = 10;
    localparam int INSTR_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = 10'h000;
    localparam logic [PC_W-1:0] PC_STEP = 10'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2} fetch_state_t;
    typedef struct packed {
        logic valid;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pc4;
        logic [INSTR_W-1:0] instr;
    } ifid_t;
    localparam ifid_t IFID_RESET = '{valid: 1'b0, pc: '0, pc4: '0, instr: NOP_INSTR};
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: hazard/redirect inputs, instruction BRAM port and IF/ID outputs of the fetch unit.
interface if_fetch_unit_if;
    import if_pkg::*;
    logic stall_i;
    logic redirect_i;
    logic [PC_W-1:0] redirect_pc_i;
    logic imem_en_o;
    logic [PC_W-1:0] imem_addr_o;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic ifid_valid_o;
    logic [PC_W-1:0] ifid_pc_o;
    logic [PC_W-1:0] ifid_pc4_o;
    logic [INSTR_W-1:0] ifid_instr_o;
    logic misaligned_o;
    modport master (
        input stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
        output imem_en_o, imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, misaligned_o
    );
    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
        input imem_en_o, imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o, misaligned_o
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: holds the BRAM word on entry to a stall so the BRAM output need not stay stable.
module fetch_skid_buf
    import if_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               capture,
    input  logic               use_hold,
    input  logic [INSTR_W-1:0] rdata,
    output logic [INSTR_W-1:0] instr
);
    logic [INSTR_W-1:0] hold_instr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_instr <= NOP_INSTR;
        else if (capture) hold_instr <= rdata;
    end
    assign instr = use_hold ? hold_instr : rdata;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register, 1-cycle BRAM fetch with stall skid and redirect flush, feeding IF/ID.
module if_fetch_unit
    import if_pkg::*;
(
    input logic clk,
    input logic rst_n,
    if_fetch_unit_if.master bus
);
    fetch_state_t state, state_n;
    logic [PC_W-1:0] fetch_pc, fetch_pc_n, f2_pc, f2_pc_n;
    logic f2_valid, f2_valid_n, mis, mis_n, en, capture;
    ifid_t ifid, ifid_n;
    logic [INSTR_W-1:0] src_instr;
    fetch_skid_buf u_skid (
        .clk(clk),
        .rst_n(rst_n),
        .capture(capture),
        .use_hold(state == STALL),
        .rdata(bus.imem_rdata_i),
        .instr(src_instr)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            fetch_pc <= RESET_PC;
            f2_pc <= '0;
            f2_valid <= 1'b0;
            ifid <= IFID_RESET;
            mis <= 1'b0;
        end else begin
            state <= state_n;
            fetch_pc <= fetch_pc_n;
            f2_pc <= f2_pc_n;
            f2_valid <= f2_valid_n;
            ifid <= ifid_n;
            mis <= mis_n;
        end
    end
    // Redirect outranks stall; the wrong-path read still issues but its slot is marked invalid.
    always_comb begin
        state_n = state;
        fetch_pc_n = fetch_pc;
        f2_pc_n = f2_pc;
        f2_valid_n = f2_valid;
        ifid_n = ifid;
        mis_n = 1'b0;
        en = 1'b0;
        capture = 1'b0;
        if (state == BOOT) begin
            en = 1'b1;
            f2_pc_n = RESET_PC;
            f2_valid_n = 1'b1;
            fetch_pc_n = RESET_PC + PC_STEP;
            state_n = RUN;
        end else if (bus.redirect_i) begin
            en = 1'b1;
            fetch_pc_n = {bus.redirect_pc_i[PC_W-1:2], 2'b00};
            f2_valid_n = 1'b0;
            ifid_n = IFID_RESET;
            mis_n = |bus.redirect_pc_i[1:0];
            state_n = RUN;
        end else if (!bus.stall_i) begin
            en = 1'b1;
            ifid_n = '{valid: f2_valid, pc: f2_pc, pc4: f2_pc + PC_STEP,
                       instr: f2_valid ? src_instr : NOP_INSTR};
            f2_pc_n = fetch_pc;
            f2_valid_n = 1'b1;
            fetch_pc_n = fetch_pc + PC_STEP;
            state_n = RUN;
        end else if (state == RUN) begin
            capture = 1'b1;
            state_n = STALL;
        end
    end
    assign bus.imem_en_o = rst_n & en;
    assign bus.imem_addr_o = fetch_pc;
    assign bus.ifid_valid_o = ifid.valid;
    assign bus.ifid_pc_o = ifid.pc;
    assign bus.ifid_pc4_o = ifid.pc4;
    assign bus.ifid_instr_o = ifid.instr;
    assign bus.misaligned_o = mis;
endmodule
